arbitro_turnos: RTL
===================

# arbitro_turnos

Round-robin arbiter that shares one 3-bit time-slice counter among up to four requesters. Grants exactly one requester at a time. Each grant lasts until the requester signals `done`, drops `req`, or uses up `SLICE` ticks. It sits between the requesting FSMs and the shared counted resource, and exposes the live slice count for observation.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters. Legal range 2..4.
- `SLICE`, default 3'd5: maximum ticks per grant. Legal range 1..7; 0 is illegal and flagged by an elaboration assertion.

Ports:
- `clk`, in, 1: single clock. All logic on rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `req`, in, N_REQ: level request per requester.
- `done`, in, N_REQ: early-release pulse. Only the bit of the granted requester is honoured.
- `tick`, in, 1: slice-advance enable, one cycle wide.
- `gnt`, out, N_REQ: one-hot or zero grant, registered.
- `busy`, out, 1: high while in GRANT.
- `count`, out, 3: current slice count, registered.
- `expire`, out, 1: one-cycle pulse when a grant ends by slice exhaustion.

## Operation
- States: IDLE, GRANT, RELEASE.
- Round-robin pointer `ptr` (2 bits) names the highest-priority requester.
- Priority search order: ptr, ptr+1, … mod N_REQ.
- **IDLE**
  - If any `req` bit is high, pick the first set bit in search order.
  - Load `gnt` with that bit, clear `count` to 0, go to GRANT.
  - Otherwise stay in IDLE with `gnt`=0.
- **GRANT** (granted index g):
  - `count` increments by 1 on each cycle with `tick`=1. It never increments outside GRANT.
  - Release conditions, evaluated each cycle:
    - (a) `done[g]`=1
    - (b) `req[g]`=0
    - (c) `tick`=1 and `count`==SLICE-1
  - Any release condition → go to RELEASE. On that edge: `gnt`=0, `count`=0, `ptr`=(g+1) mod N_REQ.
  - `expire` pulses only for (c) when (a) and (b) are both false. (a) and (b) take precedence for reporting; the release itself is identical.
  - `done` bits of non-granted requesters are ignored.
- **RELEASE**: one mandatory dead cycle with `gnt`=0. Always goes to IDLE; no arbitration happens in this state.
- Arithmetic:
  - `count` is a 3-bit unsigned value and cannot exceed SLICE-1, so it never wraps.
  - With SLICE=1, the first tick in GRANT triggers (c).
- Requests arriving mid-grant are held pending by the requester (level `req`). There is no queue inside the block.

## Timing
- Reset (`rst`=0 at an edge), taking effect next edge from any state, including mid-grant:
  - state=IDLE, `gnt`=0, `busy`=0, `count`=0, `expire`=0, `ptr`=0.
- Request to grant latency: `req` sampled high in IDLE at edge k → `gnt` high after edge k (visible in cycle k+1).
- Release:
  - A release condition sampled at edge k → `gnt`=0 and `expire` (if applicable) after edge k.
  - State is RELEASE for cycle k+1 and IDLE in cycle k+2.
- Earliest regrant after release is 2 cycles: release at edge k, RELEASE at edge k+1, grant at edge k+2.
- Minimum grant length is one cycle, when `done` is asserted in the first GRANT cycle.
- With continuous `tick` and no done, grant length is exactly SLICE cycles.
- `expire` is high for exactly one cycle per exhaustion event.
- `busy` equals (state==GRANT) and is registered together with `gnt`, so `busy` == |`gnt` always.

## Structure
- Package `arbitro_pkg`:
  - `typedef enum logic [1:0] {IDLE, GRANT, RELEASE} estado_t`
  - constant `N_REQ_MAX`=4
  - localparam `CNT_W`=3
- Sub-module `contador_turno`:
  - 3-bit up counter with sync active-low `rst`, sync `clr` (priority over `en`), `en`, and output `count`.
  - Built as three bit-level toggle/carry stages, in the same style as the existing structural counters.
- Top level holds:
  - the FSM (state register plus next-state logic)
  - the round-robin priority encoder (rotate, find-first, rotate back)
  - the `ptr` register and the `gnt`/`expire` registers.

## Test plan
- **Reset mid-grant:** grant to req[2], `count`=3, drive `rst`=0 for one edge → next cycle `gnt`=0, `count`=0, `ptr`=0, state IDLE. Release `rst` with req=4'b0110 → `gnt`=4'b0010.
- **Slice exhaustion:** SLICE=5, req=4'b0001 held, `tick` every cycle → `gnt`=0001 for 5 cycles, `count` 0..4. `expire` pulses once at the release edge, then one dead cycle, then regrant to 0001 (only requester).
- **Round robin:** req=4'b1111 held, each grantee asserts `done` in its 2nd grant cycle → grant order 0,1,2,3,0, each separated by one RELEASE cycle, `expire` never high.
- **Simultaneous done and expire:** SLICE=3, `count`=2, `tick`=1 and `done[g]`=1 in the same cycle → release occurs, `expire` stays 0, `count`=0.
- **Spurious done and request drop:** grant to requester 1, assert `done[3]` → no effect. Then drop `req[1]` with `count`=1 → release next edge, `expire`=0, `ptr`=2. Then with req=4'b0001 → grant 0001.
- **Tick gating:** `tick`=1 in IDLE and RELEASE for 10 cycles → `count` stays 0. SLICE=1 with one tick in GRANT → immediate release with `expire`=1.

Source files
------------

// File: rtl/arbitro_turnos_pkg.sv
// Shared types and constants for the round-robin time-slice arbiter.
// No logic; imported by the interface, counter and top.
package arbitro_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } estado_t;

    localparam int N_REQ_MAX = 4;
    localparam int CNT_W     = 3;

    // Wraps an index sum (always below 2*n) back into 0..n-1 without a divider.
    function automatic logic [1:0] wrap_idx(input int v, input int n);
        if (v >= n) begin
            return 2'(v - n);
        end
        return 2'(v);
    endfunction

endpackage

// File: rtl/arbitro_turnos_if.sv
// Requester-side bundle for arbitro_turnos: request/done/tick in, grant/status out.
// Pure wiring; all timing is set by the arbiter registers.
interface arbitro_turnos_if #(
    parameter int N_REQ = 4
);
    import arbitro_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic             tick;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             expire;

    modport master (
        output req, done, tick,
        input  gnt, busy, count, expire
    );

    modport slave (
        input  req, done, tick,
        output gnt, busy, count, expire
    );

endinterface

// File: rtl/arbitro_turnos_contador.sv
// 3-bit up counter built from toggle/carry stages; clr beats en; one-cycle update.
// No backpressure: counts whenever en is high and clr is low.
module contador_turno
    import arbitro_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             t0;
    logic             t1;
    logic             t2;

    // Each stage toggles when every lower bit is set and counting is enabled.
    assign t0 = en;
    assign t1 = t0 & count_q[0];
    assign t2 = t1 & count_q[1];

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else begin
            count_d[0] = count_q[0] ^ t0;
            count_d[1] = count_q[1] ^ t1;
            count_d[2] = count_q[2] ^ t2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/arbitro_turnos.sv
// Round-robin arbiter for one shared time-slice counter; grant one cycle after req, released grant idles 2 cycles.
// Requesters hold req level until granted; grant ends on done, req drop, or slice exhaustion.
module arbitro_turnos
    import arbitro_pkg::*;
#(
    parameter int               N_REQ = 4,
    parameter logic [CNT_W-1:0] SLICE = 3'd5
) (
    input  logic            clk,
    input  logic            rst,
    arbitro_turnos_if.slave bus
);

    if (SLICE == '0) begin : g_bad_slice
        $error("arbitro_turnos: SLICE must be in 1..7");
    end
    if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_nreq
        $error("arbitro_turnos: N_REQ must be in 2..4");
    end

    estado_t          state_q;
    estado_t          state_d;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] gnt_d;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic [1:0]       g_q;
    logic [1:0]       g_d;
    logic             busy_q;
    logic             busy_d;
    logic             expire_q;
    logic             expire_d;

    logic [N_REQ-1:0] req_rot;
    logic [1:0]       off;
    logic [1:0]       win_idx;
    logic             any_req;

    logic             req_g;
    logic             done_g;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_slice;
    logic             release_now;

    logic             cnt_clr;
    logic [CNT_W-1:0] count;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then map back.
    always_comb begin
        req_rot = '0;
        off     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_rot[i] = bus.req[wrap_idx(int'(ptr_q) + i, N_REQ)];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = 2'(i);
            end
        end
        any_req = |req_rot;
        win_idx = wrap_idx(int'(ptr_q) + int'(off), N_REQ);
    end

    always_comb begin
        req_g  = 1'b0;
        done_g = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g_q == 2'(i)) begin
                req_g  = bus.req[i];
                done_g = bus.done[i];
            end
        end
    end

    assign rel_done    = done_g;
    assign rel_drop    = ~req_g;
    assign rel_slice   = bus.tick && (count == (SLICE - 3'd1));
    assign release_now = rel_done | rel_drop | rel_slice;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        g_d      = g_q;
        expire_d = 1'b0;
        cnt_clr  = 1'b1;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (any_req) begin
                    state_d = GRANT;
                    g_d     = win_idx;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                end
            end
            GRANT: begin
                cnt_clr = release_now;
                if (release_now) begin
                    state_d  = RELEASE;
                    gnt_d    = '0;
                    ptr_d    = wrap_idx(int'(g_q) + 1, N_REQ);
                    // Early release by done or req drop is not reported as expiry.
                    expire_d = rel_slice & ~rel_done & ~rel_drop;
                end
            end
            RELEASE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == GRANT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            g_q      <= '0;
            busy_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            g_q      <= g_d;
            busy_q   <= busy_d;
            expire_q <= expire_d;
        end
    end

    contador_turno u_contador (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (bus.tick),
        .count (count)
    );

    assign bus.gnt    = gnt_q;
    assign bus.busy   = busy_q;
    assign bus.count  = count;
    assign bus.expire = expire_q;

endmodule
